poly_tone_gen: RTL and testbench

Multi-channel square-wave tone generator that replaces the single-voice oscillator feeding the audio codec path. It accepts timed note requests (channel, half-period, duration) from the game processor, runs up to NUM_CH independent voices with hardware duration timers, mixes them into one signed sample, and drives the Audio_Controller sample-write handshake. Voices end on their own, so the processor no longer has to toggle the audio reset to stop a tone.

---
 rtl/poly_tone_gen.sv | 208 ++++++++++++++++++++
 tb/tb_poly_tone_gen.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/poly_tone_gen.sv
// poly_tone_gen: NUM_CH-voice square-wave tone generator with per-voice
// duration timers, a signed mixer and the codec sample-write strobe.
// Optional decaying envelope: define POLY_TONE_ENV_EN.
module poly_tone_gen #(
  parameter int unsigned      NUM_CH    = 4,
  parameter int unsigned      HALF_W    = 20,
  parameter int unsigned      DUR_W     = 26,
  parameter int unsigned      OUT_W     = 32,
  parameter logic [OUT_W-1:0] AMP       = OUT_W'(32'h0100_0000),
  parameter int unsigned      ENV_SHIFT = 22
) (
  input  logic                                           CLOCK_50,
  input  logic                                           reset_n,
  input  logic                                           note_valid,
  output logic                                           note_ready,
  input  logic [((NUM_CH > 1) ? $clog2(NUM_CH) : 1)-1:0] note_ch,
  input  logic [HALF_W-1:0]                              note_half_wav,
  input  logic [DUR_W-1:0]                               note_dur,
  output logic [NUM_CH-1:0]                              ch_busy,
  output logic [NUM_CH-1:0]                              ch_done,
  input  logic                                           audio_out_allowed,
  output logic                                           write_audio_out,
  output logic [OUT_W-1:0]                               sample_out
);

  localparam int unsigned CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  // Elaboration-time sanity checks on the configuration
  if (NUM_CH < 1 || NUM_CH > 8) begin : g_bad_num_ch
    $error("poly_tone_gen: NUM_CH must be 1..8");
  end
  if (ENV_SHIFT < 1 || ENV_SHIFT > 30) begin : g_bad_env_shift
    $error("poly_tone_gen: ENV_SHIFT must be 1..30");
  end
  if ((64'(NUM_CH) * 64'(AMP)) >= (64'd1 << (OUT_W - 1))) begin : g_bad_amp
    $error("poly_tone_gen: NUM_CH*AMP overflows the signed sample");
  end

  typedef enum logic {
    V_IDLE = 1'b0,
    V_PLAY = 1'b1
  } voice_state_t;

  voice_state_t      state_q [NUM_CH];
  voice_state_t      state_d [NUM_CH];
  logic [HALF_W-1:0] phase_q [NUM_CH];
  logic [HALF_W-1:0] phase_d [NUM_CH];
  logic [HALF_W-1:0] half_q  [NUM_CH];
  logic [HALF_W-1:0] half_d  [NUM_CH];
  logic [DUR_W-1:0]  dur_q   [NUM_CH];
  logic [DUR_W-1:0]  dur_d   [NUM_CH];
  logic              pol_q   [NUM_CH];
  logic              pol_d   [NUM_CH];
  logic [NUM_CH-1:0] done_q;
  logic [NUM_CH-1:0] done_d;
  logic [NUM_CH-1:0] hit;
  logic [OUT_W-1:0]  mag     [NUM_CH];
  logic [OUT_W-1:0]  mix;
  logic              ready_q;
  logic              wr_q;
  logic [OUT_W-1:0]  sample_q;
  logic              accept;

`ifdef POLY_TONE_ENV_EN
  logic [2:0]           atten_q [NUM_CH];
  logic [2:0]           atten_d [NUM_CH];
  logic [ENV_SHIFT-1:0] env_q   [NUM_CH];
  logic [ENV_SHIFT-1:0] env_d   [NUM_CH];
`endif

  assign accept = note_valid && ready_q;

  // Decode which voice (if any) the accepted request targets
  always_comb begin
    hit = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      hit[i] = accept && (note_ch == CH_W'(i));
    end
  end

  // Per-voice next state: an accept overrides the running note, so a
  // retrigger on the final cycle suppresses that note's done pulse
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      state_d[i] = state_q[i];
      phase_d[i] = phase_q[i];
      half_d[i]  = half_q[i];
      dur_d[i]   = dur_q[i];
      pol_d[i]   = pol_q[i];
      done_d[i]  = 1'b0;
`ifdef POLY_TONE_ENV_EN
      atten_d[i] = atten_q[i];
      env_d[i]   = env_q[i];
`endif
      if (hit[i]) begin
        half_d[i]  = note_half_wav;
        dur_d[i]   = note_dur;
        phase_d[i] = '0;
        pol_d[i]   = 1'b1;
        state_d[i] = (note_dur != '0) ? V_PLAY : V_IDLE;
        done_d[i]  = (note_dur == '0);
`ifdef POLY_TONE_ENV_EN
        atten_d[i] = '0;
        env_d[i]   = '0;
`endif
      end else if (state_q[i] == V_PLAY) begin
        dur_d[i] = dur_q[i] - DUR_W'(1);
        if (half_q[i] != '0) begin
          if (phase_q[i] == half_q[i] - HALF_W'(1)) begin
            phase_d[i] = '0;
            pol_d[i]   = ~pol_q[i];
          end else begin
            phase_d[i] = phase_q[i] + HALF_W'(1);
          end
        end
        if (dur_q[i] == DUR_W'(1)) begin
          state_d[i] = V_IDLE;
          done_d[i]  = 1'b1;
        end
`ifdef POLY_TONE_ENV_EN
        env_d[i] = env_q[i] + ENV_SHIFT'(1);
        if ((env_q[i] == '1) && (atten_q[i] != 3'd7)) begin
          atten_d[i] = atten_q[i] + 3'd1;
        end
`endif
      end
    end
  end

  // Voice state registers; reset aborts all voices without done pulses
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= V_IDLE;
        phase_q[i] <= '0;
        half_q[i]  <= '0;
        dur_q[i]   <= '0;
        pol_q[i]   <= 1'b0;
`ifdef POLY_TONE_ENV_EN
        atten_q[i] <= '0;
        env_q[i]   <= '0;
`endif
      end
      done_q  <= '0;
      ready_q <= 1'b0;
    end else begin
      for (int unsigned i = 0; i < NUM_CH; i++) begin
        state_q[i] <= state_d[i];
        phase_q[i] <= phase_d[i];
        half_q[i]  <= half_d[i];
        dur_q[i]   <= dur_d[i];
        pol_q[i]   <= pol_d[i];
`ifdef POLY_TONE_ENV_EN
        atten_q[i] <= atten_d[i];
        env_q[i]   <= env_d[i];
`endif
      end
      done_q  <= done_d;
      ready_q <= 1'b1;
    end
  end

  // Per-voice peak magnitude (attenuated when the envelope is built in)
  always_comb begin
    for (int unsigned i = 0; i < NUM_CH; i++) begin
`ifdef POLY_TONE_ENV_EN
      mag[i] = AMP >> atten_q[i];
`else
      mag[i] = AMP;
`endif
    end
  end

  // Two's-complement mix of all sounding voices; AMP bound rules out overflow
  always_comb begin
    mix = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      if ((state_q[i] == V_PLAY) && (half_q[i] != '0)) begin
        mix = pol_q[i] ? (mix + mag[i]) : (mix - mag[i]);
      end
    end
  end

  // Codec handshake: strobe follows allowed by one cycle, sample holds otherwise
  always_ff @(posedge CLOCK_50 or negedge reset_n) begin
    if (!reset_n) begin
      wr_q     <= 1'b0;
      sample_q <= '0;
    end else begin
      wr_q <= audio_out_allowed;
      if (audio_out_allowed) begin
        sample_q <= mix;
      end
    end
  end

  // Output mapping
  always_comb begin
    note_ready      = ready_q;
    ch_done         = done_q;
    write_audio_out = wr_q;
    sample_out      = sample_q;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      ch_busy[i] = (state_q[i] == V_PLAY);
    end
  end

endmodule

// File: tb/tb_poly_tone_gen.sv
// Self-checking bench for poly_tone_gen (default build, envelope disabled).
module tb_poly_tone_gen;

  localparam logic [31:0] A = 32'h0100_0000;

  logic        clk;
  logic        reset_n;
  logic        note_valid;
  logic        note_ready;
  logic [1:0]  note_ch;
  logic [19:0] note_half_wav;
  logic [25:0] note_dur;
  logic [3:0]  ch_busy;
  logic [3:0]  ch_done;
  logic        audio_out_allowed;
  logic        write_audio_out;
  logic [31:0] sample_out;

  int nvec = 0;
  int nerr = 0;

  poly_tone_gen #(
    .NUM_CH(4),
    .HALF_W(20),
    .DUR_W(26),
    .OUT_W(32),
    .AMP(32'h0100_0000),
    .ENV_SHIFT(22)
  ) dut (
    .CLOCK_50(clk),
    .reset_n(reset_n),
    .note_valid(note_valid),
    .note_ready(note_ready),
    .note_ch(note_ch),
    .note_half_wav(note_half_wav),
    .note_dur(note_dur),
    .ch_busy(ch_busy),
    .ch_done(ch_done),
    .audio_out_allowed(audio_out_allowed),
    .write_audio_out(write_audio_out),
    .sample_out(sample_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  typedef struct {
    bit          issue;
    int          ch;
    int          half;
    int          dur;
    int          k;
    logic [3:0]  busy;
    logic [3:0]  done;
    logic [31:0] smp;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(bit issue, int ch, int half, int dur, int k,
                              logic [3:0] busy, logic [3:0] done, logic [31:0] smp);
    vec_t v;
    v.issue = issue; v.ch = ch; v.half = half; v.dur = dur; v.k = k;
    v.busy = busy; v.done = done; v.smp = smp;
    tbl.push_back(v);
  endfunction

  // Reference contribution of one voice, j cycles after its accept edge
  function automatic logic [31:0] contrib(int j, int half, int dur);
    if (j < 0 || j >= dur || half == 0) return 32'h0;
    return (((j / half) % 2) == 0) ? A : -A;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step(int n);
    if (n > 0) begin
      repeat (n) @(posedge clk);
      #1;
    end
  endtask

  // Present one request; returns #1 after its accept edge
  task automatic issue(int ch, int half, int dur);
    int w = 0;
    while (!note_ready && w < 20) begin
      @(posedge clk); #1; w++;
    end
    if (!note_ready) begin
      nvec++; nerr++;
      $display("FAIL ready_timeout: got 0 expected 1");
    end
    @(negedge clk);
    note_valid    = 1'b1;
    note_ch       = 2'(ch);
    note_half_wav = 20'(half);
    note_dur      = 26'(dur);
    @(posedge clk);
    #1;
    note_valid = 1'b0;
  endtask

  initial begin
    int          cur_k;
    logic [31:0] exp_s;
    logic        alw;

    reset_n           = 1'b0;
    note_valid        = 1'b0;
    note_ch           = '0;
    note_half_wav     = '0;
    note_dur          = '0;
    audio_out_allowed = 1'b1;

    // Table: single-voice notes checked at offsets k after the accept edge
    add(1, 0, 5, 23,  0, 4'b0001, 4'b0000, 32'h0);
    add(0, 0, 5, 23,  1, 4'b0001, 4'b0000, A);
    add(0, 0, 5, 23,  5, 4'b0001, 4'b0000, A);
    add(0, 0, 5, 23,  6, 4'b0001, 4'b0000, -A);
    add(0, 0, 5, 23, 11, 4'b0001, 4'b0000, A);
    add(0, 0, 5, 23, 16, 4'b0001, 4'b0000, -A);
    add(0, 0, 5, 23, 22, 4'b0001, 4'b0000, A);
    add(0, 0, 5, 23, 23, 4'b0000, 4'b0001, A);
    add(0, 0, 5, 23, 24, 4'b0000, 4'b0000, 32'h0);
    add(1, 3, 0, 4,   0, 4'b1000, 4'b0000, 32'h0);
    add(0, 3, 0, 4,   2, 4'b1000, 4'b0000, 32'h0);
    add(0, 3, 0, 4,   4, 4'b0000, 4'b1000, 32'h0);
    add(0, 3, 0, 4,   5, 4'b0000, 4'b0000, 32'h0);
    add(1, 1, 7, 0,   0, 4'b0000, 4'b0010, 32'h0);
    add(0, 1, 7, 0,   1, 4'b0000, 4'b0000, 32'h0);
    add(1, 2, 1, 4,   0, 4'b0100, 4'b0000, 32'h0);
    add(0, 2, 1, 4,   1, 4'b0100, 4'b0000, A);
    add(0, 2, 1, 4,   2, 4'b0100, 4'b0000, -A);
    add(0, 2, 1, 4,   3, 4'b0100, 4'b0000, A);
    add(0, 2, 1, 4,   4, 4'b0000, 4'b0100, -A);
    add(0, 2, 1, 4,   5, 4'b0000, 4'b0000, 32'h0);

    // Reset state, including strobe held low although allowed is high
    #1;
    chk("rst_ready",  {31'b0, note_ready}, 32'h0);
    chk("rst_busy",   {28'b0, ch_busy}, 32'h0);
    step(3);
    chk("rst_wr",     {31'b0, write_audio_out}, 32'h0);
    chk("rst_sample", sample_out, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel_ready_before_edge", {31'b0, note_ready}, 32'h0);
    @(posedge clk); #1;
    chk("rel_ready_after_edge", {31'b0, note_ready}, 32'h1);
    chk("rel_wr", {31'b0, write_audio_out}, 32'h1);

    // Table-driven vectors
    cur_k = 0;
    for (int i = 0; i < tbl.size(); i++) begin
      if (tbl[i].issue) begin
        issue(tbl[i].ch, tbl[i].half, tbl[i].dur);
        cur_k = 0;
      end
      step(tbl[i].k - cur_k);
      cur_k = tbl[i].k;
      chk($sformatf("vec%0d_busy", i),   {28'b0, ch_busy}, {28'b0, tbl[i].busy});
      chk($sformatf("vec%0d_done", i),   {28'b0, ch_done}, {28'b0, tbl[i].done});
      chk($sformatf("vec%0d_wr", i),     {31'b0, write_audio_out}, 32'h1);
      chk($sformatf("vec%0d_sample", i), sample_out, tbl[i].smp);
    end

    // Chord: ch0 half=3 at T, ch1 half=4 at T+1, both dur=30
    @(negedge clk);
    note_valid = 1'b1; note_ch = 2'd0; note_half_wav = 20'd3; note_dur = 26'd30;
    @(posedge clk); #1;
    note_ch = 2'd1; note_half_wav = 20'd4;
    @(posedge clk); #1;
    note_valid = 1'b0;
    chk("chord_busy", {28'b0, ch_busy}, 32'h3);
    for (int k = 2; k <= 33; k++) begin
      step(1);
      chk($sformatf("chord_k%0d_sample", k), sample_out,
          contrib(k - 1, 3, 30) + contrib(k - 2, 4, 30));
      chk($sformatf("chord_k%0d_done", k), {28'b0, ch_done},
          {28'b0, 2'b00, (k == 31), (k == 30)});
    end

    // Retrigger ch2 on its final cycle: no done pulse, busy continues
    issue(2, 2, 10);
    step(9);
    chk("retrig_pre_busy", {31'b0, ch_busy[2]}, 32'h1);
    issue(2, 3, 5);
    chk("retrig_k10_busy", {31'b0, ch_busy[2]}, 32'h1);
    chk("retrig_k10_done", {31'b0, ch_done[2]}, 32'h0);
    for (int k = 11; k <= 16; k++) begin
      step(1);
      chk($sformatf("retrig_k%0d_done", k), {31'b0, ch_done[2]}, {31'b0, (k == 15)});
      chk($sformatf("retrig_k%0d_busy", k), {31'b0, ch_busy[2]}, {31'b0, (k < 15)});
      if (k == 11) chk("retrig_k11_sample", sample_out, A);
    end

    // Handshake: random allowed, strobe delayed by one, sample frozen when low
    issue(0, 3, 60);
    exp_s = 32'h0;
    chk("hs_k0_sample", sample_out, exp_s);
    for (int k = 1; k <= 64; k++) begin
      alw = 1'($urandom_range(0, 1));
      audio_out_allowed = alw;
      step(1);
      if (alw) exp_s = contrib(k - 1, 3, 60);
      chk($sformatf("hs_k%0d_wr", k), {31'b0, write_audio_out}, {31'b0, alw});
      chk($sformatf("hs_k%0d_sample", k), sample_out, exp_s);
    end
    audio_out_allowed = 1'b1;
    step(2);

    // Reset mid-note aborts silently
    issue(0, 4, 50);
    step(5);
    reset_n = 1'b0;
    #1;
    chk("midrst_busy",   {28'b0, ch_busy}, 32'h0);
    chk("midrst_sample", sample_out, 32'h0);
    chk("midrst_ready",  {31'b0, note_ready}, 32'h0);
    step(2);
    chk("midrst_done",   {28'b0, ch_done}, 32'h0);
    @(negedge clk);
    reset_n = 1'b1;
    step(1);
    chk("postrst_ready",  {31'b0, note_ready}, 32'h1);
    chk("postrst_busy",   {28'b0, ch_busy}, 32'h0);
    chk("postrst_done",   {28'b0, ch_done}, 32'h0);
    chk("postrst_sample", sample_out, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
